// File: rtl/onchip_ram_burst.sv
// Single-port on-chip RAM with an Avalon-style burst slave interface.
// Fixed-length write and read bursts, global clock enable, 1- or 2-cycle read latency.
module onchip_ram_burst #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 8,
    localparam int unsigned BW          = $clog2(MAX_BURST) + 1,
    localparam int unsigned NB          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [BW-1:0]         burstcount,
    input  logic [NB-1:0]         byteenable,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic                  clken,
    output logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
);

    typedef enum logic [1:0] {StIdle, StWBurst, StRBurst} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           eff_len;
    logic                    accept;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    rd_issue;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [DATA_WIDTH-1:0]   last_q;
    logic [READ_LATENCY-1:0] vld_q;

    assign waitrequest = reset | ~clken | (state_q == StRBurst);
    assign accept      = chipselect & (read | write) & clken & ~waitrequest;

    always_comb begin
        if (burstcount == '0) begin
            eff_len = BW'(1);
        end else if (burstcount > BW'(MAX_BURST)) begin
            eff_len = BW'(MAX_BURST);
        end else begin
            eff_len = burstcount;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_addr  = addr_q;
        rd_issue = 1'b0;
        rd_addr  = addr_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    // Write wins when both strobes are up; the read is dropped.
                    if (write) begin
                        wr_en   = 1'b1;
                        wr_addr = address;
                    end else begin
                        rd_issue = 1'b1;
                        rd_addr  = address;
                    end
                    if (eff_len > BW'(1)) begin
                        addr_d  = address + ADDR_WIDTH'(1);
                        cnt_d   = eff_len - BW'(1);
                        state_d = write ? StWBurst : StRBurst;
                    end
                end
            end
            StWBurst: begin
                if (chipselect && write && clken) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - BW'(1);
                    if (cnt_q == BW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StRBurst: begin
                if (clken) begin
                    rd_issue = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    cnt_d    = cnt_q - BW'(1);
                    if (cnt_q == BW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array and its read register stay unreset so the tools can map them to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    mem[wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
        if (rd_issue) begin
            mem_rdata <= mem[rd_addr];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] pipe_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
            end else if (clken) begin
                vld_q <= {vld_q[0], rd_issue};
            end
        end

        always_ff @(posedge clk) begin
            if (clken) begin
                pipe_q <= mem_rdata;
            end
        end

        assign out_data = pipe_q;
    end else begin : g_lat1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
            end else if (clken) begin
                vld_q <= rd_issue;
            end
        end

        assign out_data = mem_rdata;
    end

    assign readdatavalid = vld_q[READ_LATENCY-1] & clken & ~reset;
    // Between pulses the output shows the last delivered beat, not the pending one.
    assign readdata      = readdatavalid ? out_data : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
        end else if (readdatavalid) begin
            last_q <= out_data;
        end
    end

endmodule

// File: tb/tb_onchip_ram_burst.sv
// Bench for onchip_ram_burst: latency-1 and latency-2 instances share stimulus,
// each read beat is checked against a per-instance queue of expected words.
module tb_onchip_ram_burst;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [9:0]  address;
    logic [3:0]  burstcount;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        clken;

    logic        wr1, wr2;
    logic [15:0] rd1, rd2;
    logic        rdv1, rdv2;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [1024];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [15:0] last1, last2;
    logic [15:0] e1, e2;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    onchip_ram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(1), .MAX_BURST(8)) dut1 (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .burstcount(burstcount), .byteenable(byteenable),
        .writedata(writedata), .clken(clken), .waitrequest(wr1), .readdata(rd1),
        .readdatavalid(rdv1)
    );

    onchip_ram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(2), .MAX_BURST(8)) dut2 (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .burstcount(burstcount), .byteenable(byteenable),
        .writedata(writedata), .clken(clken), .waitrequest(wr2), .readdata(rd2),
        .readdatavalid(rdv2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mwrite(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        for (int b = 0; b < 2; b++) begin
            if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic wr_single(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be; burstcount = 4'd1;
        mwrite(a, d, be);
        cycle();
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Beats after the first carry junk on address; stall_at inserts one chipselect-low cycle.
    task automatic wr_burst(input logic [9:0] a, input logic [15:0] base, input int n,
                            input int stall_at);
        logic [9:0] ai;
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = base; byteenable = 2'b11; burstcount = 4'(n);
        mwrite(a, base, 2'b11);
        cycle();
        for (int i = 1; i < n; i++) begin
            address = 10'd300;
            if (i == stall_at) begin
                chipselect = 1'b0;
                writedata  = 16'hDEAD;
                cycle();
                chipselect = 1'b1;
            end
            ai = a + 10'(i);
            writedata = base + 16'(i);
            mwrite(ai, writedata, 2'b11);
            cycle();
        end
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_raw(input logic [9:0] a, input logic [3:0] bc);
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address = a; burstcount = bc;
        #1;
        check("rd_cmd_wait1", 32'(wr1), 32'd0);
        check("rd_cmd_wait2", 32'(wr2), 32'd0);
        cycle();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic rd_cmd(input logic [9:0] a, input logic [3:0] bc);
        int         len;
        logic [9:0] ai;
        len = (bc == 4'd0) ? 1 : (bc > 4'd8) ? 8 : int'(bc);
        for (int i = 0; i < len; i++) begin
            ai = a + 10'(i);
            q1.push_back(model[ai]);
            q2.push_back(model[ai]);
        end
        rd_raw(a, bc);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(q1.size() + q2.size()), 32'd0);
        repeat (3) cycle();
    endtask

    // Scoreboard: every pulse pops one expected word; between pulses readdata must hold.
    always @(negedge clk) begin
        if (reset) begin
            last1 = '0;
            last2 = '0;
        end else begin
            if (rdv1) begin
                if (q1.size() == 0) begin
                    check("rdv1_unexpected", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("rd1_data", 32'(rd1), 32'(e1));
                    last1 = e1;
                end
            end else begin
                check("rd1_hold", 32'(rd1), 32'(last1));
            end
            if (rdv2) begin
                if (q2.size() == 0) begin
                    check("rdv2_unexpected", 32'd1, 32'd0);
                end else begin
                    e2 = q2.pop_front();
                    check("rd2_data", 32'(rd2), 32'(e2));
                    last2 = e2;
                end
            end else begin
                check("rd2_hold", 32'(rd2), 32'(last2));
            end
            if (!clken) begin
                check("rdv_during_clken0", 32'({rdv1, rdv2}), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{10'd5,    16'hA5A5, 2'b11, 16'hA5A5};
        vecs[1] = '{10'd7,    16'hFFFF, 2'b11, 16'hFFFF};
        vecs[2] = '{10'd7,    16'h1234, 2'b01, 16'hFF34};
        vecs[3] = '{10'd7,    16'hABCD, 2'b10, 16'hAB34};
        vecs[4] = '{10'd1023, 16'h0F0F, 2'b11, 16'h0F0F};
        vecs[5] = '{10'd0,    16'hBEEF, 2'b11, 16'hBEEF};

        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; burstcount = '0; byteenable = '0; writedata = '0; clken = 1'b1;
        #3;
        check("reset_wait1", 32'(wr1), 32'd1);
        check("reset_wait2", 32'(wr2), 32'd1);
        check("reset_rdv", 32'({rdv1, rdv2}), 32'd0);
        check("reset_rd1", 32'(rd1), 32'd0);
        check("reset_rd2", 32'(rd2), 32'd0);
        repeat (2) cycle();
        reset = 1'b0;

        // Single-beat write then read, with byte-enable merging and latency per instance.
        foreach (vecs[k]) begin
            wr_single(vecs[k].addr, vecs[k].data, vecs[k].be);
            q1.push_back(vecs[k].exp);
            q2.push_back(vecs[k].exp);
            rd_raw(vecs[k].addr, 4'd1);
            @(negedge clk);
            check("lat1_pulse", 32'(rdv1), 32'd1);
            check("lat2_not_yet", 32'(rdv2), 32'd0);
            @(negedge clk);
            check("lat2_pulse", 32'(rdv2), 32'd1);
            drain("vec_drain");
        end

        // Write burst across the wrap point with a mid-burst stall, then read it back.
        wr_burst(10'd1022, 16'd1, 4, 2);
        rd_cmd(10'd1022, 4'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rburst_wait", 32'(wr1), (i < 3) ? 32'd1 : 32'd0);
            check("rburst_consecutive", 32'(rdv1), 32'd1);
        end
        drain("wrap_drain");
        check("junk_addr_untouched", 32'(q1.size()), 32'd0);

        // Eight-beat read with clken low for two cycles mid-burst.
        wr_burst(10'd0, 16'h0100, 8, 0);
        rd_cmd(10'd0, 4'd8);
        repeat (2) cycle();
        clken = 1'b0;
        #1;
        check("clken0_wait", 32'(wr1), 32'd1);
        repeat (2) cycle();
        clken = 1'b1;
        drain("clken_drain");

        // Read and write together: write wins, no read beat is produced.
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = 10'd30; writedata = 16'h3C3C; byteenable = 2'b11; burstcount = 4'd1;
        mwrite(10'd30, 16'h3C3C, 2'b11);
        cycle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (3) cycle();
        rd_cmd(10'd30, 4'd1);
        drain("rw_drain");

        // Burst length clamping.
        rd_cmd(10'd5, 4'd0);
        drain("len0_drain");
        rd_cmd(10'd0, 4'd15);
        drain("len15_drain");

        // Reset during a read burst after two issues.
        rd_cmd(10'd0, 4'd8);
        cycle();
        reset = 1'b1;
        q1.delete();
        q2.delete();
        #1;
        check("abort_rdv", 32'({rdv1, rdv2}), 32'd0);
        check("abort_wait", 32'(wr1), 32'd1);
        check("abort_rd", 32'(rd1), 32'd0);
        cycle();
        reset = 1'b0;
        rd_cmd(10'd5, 4'd1);
        drain("post_reset_drain");
        rd_cmd(10'd1023, 4'd2);
        drain("post_reset_wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onchip_ram_burst.md
ONCHIP_RAM_BURST -- requirements
Module: onchip_ram_burst

Interface
REQ-001 Parameter DATA_WIDTH, default 16, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, word address width; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1, cycles from read issue to readdatavalid; legal values 1 or 2.
REQ-004 Parameter MAX_BURST, default 8, power of 2; BW = log2(MAX_BURST)+1.
REQ-005 Ports (one clock; reset is asynchronous and active-high):
  clk  in  1  sole clock
  reset  in  1  asynchronous, active-high reset
  chipselect  in  1  slave select
  read  in  1  read request
  write  in  1  write request
  address  in  ADDR_WIDTH  word address, sampled on command accept only
  burstcount  in  BW  beats in burst
  byteenable  in  DATA_WIDTH/8  per-byte write enable
  writedata  in  DATA_WIDTH  write data
  clken  in  1  global clock enable
  waitrequest  out  1  command/beat not accepted this cycle
  readdata  out  DATA_WIDTH  read data
  readdatavalid  out  1  readdata valid this cycle

Function
REQ-006 Memory SHALL be an inferred synchronous array of 2**ADDR_WIDTH x DATA_WIDTH words, optionally preloaded, never reset.
REQ-007 FSM states IDLE, WBURST, RBURST; accept = chipselect & (read|write) & clken & ~waitrequest.
REQ-008 waitrequest SHALL be 1 when clken=0, when reset=1, or in RBURST; else 0.
REQ-009 Effective burst length L = 1 if burstcount=0, MAX_BURST if burstcount>MAX_BURST, else burstcount.
REQ-010 IDLE, write accepted: beat 0 written at address with byteenable; if L>1 latch address+1 and L-1 remaining, go WBURST.
REQ-011 WBURST: each cycle with chipselect & write & clken writes writedata at internal address, increments address, decrements count; address input ignored; chipselect or write low stalls without writing; return to IDLE after last beat.
REQ-012 IDLE, read accepted: beat 0 issued at address in accept cycle; if L>1 go RBURST with address+1, L-1 remaining.
REQ-013 RBURST: one read issued per clken cycle regardless of chipselect/read; return to IDLE in cycle after last issue; next command accepted earliest that cycle.
REQ-014 Each issued read SHALL produce exactly one readdatavalid pulse, READ_LATENCY enabled cycles after issue, data in issue order.
REQ-015 Internal address SHALL wrap from 2**ADDR_WIDTH-1 to 0.
REQ-016 read and write both asserted in IDLE: write accepted, read dropped.
REQ-017 Read issued cycle after write to same address SHALL return new data; only bytes with byteenable=1 modified.
REQ-018 clken=0: all state, counters and read pipeline hold; no memory write; readdatavalid forced 0; held beats emerge after clken returns to 1.
REQ-019 readdata SHALL hold last valid value while readdatavalid=0.

Reset
REQ-020 reset=1 SHALL asynchronously force FSM IDLE, counters and internal address 0, pipeline valid bits 0, readdatavalid 0, readdata 0, waitrequest 1.
REQ-021 Reset mid-burst aborts the burst; in-flight reads SHALL produce no readdatavalid; already-written words remain.
REQ-022 First command accepted in first cycle after reset deasserts with clken=1.

Verification
REQ-023 Write 0xA5A5 to addr 5, byteenable=2'b11; read addr 5, L=1, READ_LATENCY=1 -> readdatavalid one cycle after accept, readdata=0xA5A5.
REQ-024 Write 0xFFFF then 0x1234 with byteenable=2'b01 to addr 7; read -> 0xFF34.
REQ-025 Write burst of 4 at addr 1022 data 1,2,3,4 with chipselect dropped one cycle mid-burst; read burst 4 at 1022 -> waitrequest=1 for 3 cycles, 4 consecutive readdatavalid pulses, data 1,2,3,4; addresses 1022,1023,0,1.
REQ-026 READ_LATENCY=2, read burst 8 at addr 0, clken low 2 cycles mid-burst -> exactly 8 pulses, in order, none during clken=0.
REQ-027 Assert reset during RBURST after 2 issues of burstcount=8 -> readdatavalid 0 immediately and after release, waitrequest 0 next cycle, new single read returns correct data.
REQ-028 burstcount=0 and burstcount=15 (MAX_BURST=8) reads -> exactly 1 and 8 readdatavalid pulses respectively.
